// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-unit types and constants
package cpu_pkg;

  localparam int PC_W  = 16;
  localparam int OFF_W = 10;

  localparam logic [PC_W-1:0] VECTOR_ADDR_DEFAULT = 16'hFFFE;

  typedef enum logic [2:0] {
    ST_VEC   = 3'd0,
    ST_FETCH = 3'd1,
    ST_HOLD  = 3'd2,
    ST_HALT  = 3'd3
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - program memory rd/ready read port
interface inst_fetch_unit_if;
  import cpu_pkg::*;

  logic            mem_rd;
  logic [PC_W-1:0] mem_addr;
  logic [15:0]     mem_rdata;
  logic            mem_ready;

  modport master (output mem_rd, output mem_addr, input mem_rdata, input mem_ready);
  modport slave  (input mem_rd, input mem_addr, output mem_rdata, output mem_ready);

endinterface

// File: rtl/fetch_pc_adder.sv
// rtl/fetch_pc_adder.sv - next-PC arithmetic: sequential step or relative jump
module fetch_pc_adder
  import cpu_pkg::*;
(
  input  logic [PC_W-1:0]  pc,
  input  logic             branch_en,
  input  logic             en_pc_2,
  input  logic [OFF_W-1:0] pc_offset,
  output logic [PC_W-1:0]  next_pc
);

  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] rel_bytes;

  assign seq_pc = pc + PC_W'(2);
  // Word offset -> sign-extended byte offset; sum wraps modulo 2^16.
  assign rel_bytes = {{(PC_W-OFF_W-1){pc_offset[OFF_W-1]}}, pc_offset, 1'b0};

  always_comb begin
    next_pc = pc;
    if (branch_en) begin
      next_pc = seq_pc + rel_bytes;
    end else if (en_pc_2) begin
      next_pc = seq_pc;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch unit: reset vector, PC, fetch/hold FSM
module inst_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] VECTOR_ADDR    = VECTOR_ADDR_DEFAULT,
  parameter int              TIMEOUT_CYCLES = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pc_inc,
  input  logic                   en_pc_2,
  input  logic                   branch_en,
  input  logic [OFF_W-1:0]       pc_offset,
  inst_fetch_unit_if.master      mem,
  output logic [15:0]            instruction,
  output logic                   inst_valid,
  output logic [PC_W-1:0]        pc,
  output logic                   bus_err,
  output logic [2:0]             fetch_state
);

  fetch_state_e    state, state_next;
  logic [7:0]      wait_cnt, wait_next;
  logic            rd_req;
  logic            xfer_done;
  logic            timeout;
  logic [PC_W-1:0] next_pc;

  fetch_pc_adder u_pc_adder (
    .pc        (pc),
    .branch_en (branch_en),
    .en_pc_2   (en_pc_2),
    .pc_offset (pc_offset),
    .next_pc   (next_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_VEC;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    rd_req        = 1'b0;
    mem.mem_addr  = pc;
    xfer_done     = 1'b0;
    timeout       = 1'b0;
    wait_next     = wait_cnt;
    case (state)
      ST_VEC: begin
        rd_req       = 1'b1;
        mem.mem_addr = VECTOR_ADDR;
      end
      ST_FETCH: rd_req = 1'b1;
      ST_HOLD: begin
        if (pc_inc) begin
          state_next = ST_FETCH;
          wait_next  = 8'd0;
        end
      end
      default: state_next = ST_HALT;
    endcase
    // Shared completion / wait-state handling for the two reading states.
    if (rd_req) begin
      if (mem.mem_ready) begin
        xfer_done  = 1'b1;
        wait_next  = 8'd0;
        state_next = (state == ST_VEC) ? ST_FETCH : ST_HOLD;
      end else begin
        wait_next = wait_cnt + 8'd1;
        if (wait_next == 8'(TIMEOUT_CYCLES)) begin
          timeout    = 1'b1;
          state_next = ST_HALT;
        end
      end
    end
  end

  assign mem.mem_rd  = rd_req & ~rst;
  assign fetch_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      instruction <= '0;
      inst_valid  <= 1'b0;
      bus_err     <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      wait_cnt <= wait_next;
      if (state == ST_VEC && xfer_done) begin
        pc <= {mem.mem_rdata[15:1], 1'b0};
      end
      if (state == ST_FETCH && xfer_done) begin
        instruction <= mem.mem_rdata;
        inst_valid  <= 1'b1;
      end
      if (state == ST_HOLD && pc_inc) begin
        inst_valid <= 1'b0;
        pc         <= next_pc;
      end
      if (timeout) begin
        bus_err    <= 1'b1;
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed vector bench for inst_fetch_unit
module tb_inst_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, pc_inc, en_pc_2, branch_en;
  logic [9:0]  pc_offset;
  logic [15:0] instruction, pc;
  logic        inst_valid, bus_err;
  logic [2:0]  fetch_state;

  logic [15:0] a_pc, a_next;
  logic        a_br, a_en2;
  logic [9:0]  a_off;

  logic [15:0] mem_img [0:32767];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  inst_fetch_unit_if bus ();
  assign bus.mem_rdata = mem_img[bus.mem_addr[15:1]];

  inst_fetch_unit #(.VECTOR_ADDR(16'hFFFE), .TIMEOUT_CYCLES(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_inc      (pc_inc),
    .en_pc_2     (en_pc_2),
    .branch_en   (branch_en),
    .pc_offset   (pc_offset),
    .mem         (bus),
    .instruction (instruction),
    .inst_valid  (inst_valid),
    .pc          (pc),
    .bus_err     (bus_err),
    .fetch_state (fetch_state)
  );

  fetch_pc_adder u_adder (
    .pc        (a_pc),
    .branch_en (a_br),
    .en_pc_2   (a_en2),
    .pc_offset (a_off),
    .next_pc   (a_next)
  );

  typedef struct {
    logic [15:0] pc;
    logic        br;
    logic        en2;
    logic [9:0]  off;
    logic [15:0] exp;
  } add_vec_t;

  typedef struct {
    logic        en2;
    logic        br;
    logic [9:0]  off;
    logic [15:0] exp_pc;
  } seq_vec_t;

  add_vec_t add_tab [8];
  seq_vec_t seq_a   [5];
  seq_vec_t seq_b   [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hold(input string name);
    int n = 0;
    while (fetch_state != 3'd2 && n < 40) begin
      tick();
      n++;
    end
    chk(name, 32'(fetch_state), 32'd2);
  endtask

  task automatic run_seq(input seq_vec_t v, input string name);
    en_pc_2   = v.en2;
    branch_en = v.br;
    pc_offset = v.off;
    pc_inc    = 1'b1;
    tick();
    pc_inc    = 1'b0;
    en_pc_2   = 1'b0;
    branch_en = 1'b0;
    chk({name, "_pc"}, 32'(pc), 32'(v.exp_pc));
    chk({name, "_state"}, 32'(fetch_state), 32'd1);
    wait_hold({name, "_hold"});
    chk({name, "_instr"}, 32'(instruction), 32'(mem_img[v.exp_pc[15:1]]));
    chk({name, "_valid"}, 32'(inst_valid), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem_img[i] = 16'(i * 7) ^ 16'h1234;
    mem_img[16'hFFFE >> 1] = 16'hC001;
    mem_img[16'hC000 >> 1] = 16'h4A0B;
    mem_img[16'hC002 >> 1] = 16'h5102;

    add_tab[0] = '{16'hC010, 1'b1, 1'b0, 10'h3FF, 16'hC010};
    add_tab[1] = '{16'hC010, 1'b1, 1'b0, 10'h200, 16'hBC12};
    add_tab[2] = '{16'hC010, 1'b1, 1'b1, 10'h200, 16'hBC12};
    add_tab[3] = '{16'hFFFE, 1'b0, 1'b1, 10'h000, 16'h0000};
    add_tab[4] = '{16'h0000, 1'b1, 1'b0, 10'h3FE, 16'hFFFE};
    add_tab[5] = '{16'hC000, 1'b0, 1'b0, 10'h005, 16'hC000};
    add_tab[6] = '{16'h1000, 1'b1, 1'b0, 10'h1FF, 16'h1400};
    add_tab[7] = '{16'hC000, 1'b0, 1'b1, 10'h155, 16'hC002};

    seq_a[0] = '{1'b0, 1'b1, 10'h006, 16'hC010};
    seq_a[1] = '{1'b0, 1'b1, 10'h3FF, 16'hC010};
    seq_a[2] = '{1'b1, 1'b1, 10'h200, 16'hBC12};
    seq_a[3] = '{1'b0, 1'b0, 10'h000, 16'hBC12};
    seq_a[4] = '{1'b1, 1'b0, 10'h000, 16'hBC14};

    seq_b[0] = '{1'b1, 1'b0, 10'h000, 16'h0000};
    seq_b[1] = '{1'b0, 1'b1, 10'h3FE, 16'hFFFE};
    seq_b[2] = '{1'b0, 1'b1, 10'h001, 16'h0002};

    for (int i = 0; i < 8; i++) begin
      a_pc  = add_tab[i].pc;
      a_br  = add_tab[i].br;
      a_en2 = add_tab[i].en2;
      a_off = add_tab[i].off;
      #1;
      chk($sformatf("adder_%0d", i), 32'(a_next), 32'(add_tab[i].exp));
    end

    rst = 1'b1; pc_inc = 1'b0; en_pc_2 = 1'b0; branch_en = 1'b0; pc_offset = '0;
    bus.mem_ready = 1'b1;
    tick(); tick();
    chk("rst_state", 32'(fetch_state), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_buserr", 32'(bus_err), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_instr", 32'(instruction), 32'd0);
    chk("rst_memrd", 32'(bus.mem_rd), 32'd0);

    rst = 1'b0;
    #1;
    chk("vec_memrd", 32'(bus.mem_rd), 32'd1);
    chk("vec_addr", 32'(bus.mem_addr), 32'hFFFE);
    tick();
    chk("vec_state", 32'(fetch_state), 32'd1);
    chk("vec_pc", 32'(pc), 32'hC000);
    chk("fetch_addr", 32'(bus.mem_addr), 32'hC000);
    chk("fetch_valid0", 32'(inst_valid), 32'd0);
    tick();
    chk("cyc3_valid", 32'(inst_valid), 32'd1);
    chk("cyc3_instr", 32'(instruction), 32'h4A0B);
    chk("hold_memrd", 32'(bus.mem_rd), 32'd0);

    pc_inc = 1'b1; en_pc_2 = 1'b1;
    tick();
    pc_inc = 1'b0; en_pc_2 = 1'b0;
    chk("seq_pc", 32'(pc), 32'hC002);
    chk("seq_valid0", 32'(inst_valid), 32'd0);
    tick();
    chk("seq_instr", 32'(instruction), 32'h5102);

    for (int i = 0; i < 5; i++) run_seq(seq_a[i], $sformatf("seqA_%0d", i));

    // Three wait states with pc_inc held high in FETCH (must be ignored).
    pc_inc = 1'b1; en_pc_2 = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ws_memrd_%0d", i), 32'(bus.mem_rd), 32'd1);
      chk($sformatf("ws_state_%0d", i), 32'(fetch_state), 32'd1);
      tick();
    end
    chk("ws_pc_hold", 32'(pc), 32'hBC16);
    chk("ws_valid0", 32'(inst_valid), 32'd0);
    pc_inc = 1'b0; en_pc_2 = 1'b0; bus.mem_ready = 1'b1;
    tick();
    chk("ws_state_hold", 32'(fetch_state), 32'd2);
    chk("ws_instr", 32'(instruction), 32'(mem_img[16'hBC16 >> 1]));

    pc_inc = 1'b1; en_pc_2 = 1'b1;
    tick();
    pc_inc = 1'b0; en_pc_2 = 1'b0; bus.mem_ready = 1'b0;
    repeat (14) tick();
    chk("to_state14", 32'(fetch_state), 32'd1);
    chk("to_buserr14", 32'(bus_err), 32'd0);
    tick();
    chk("to_state15", 32'(fetch_state), 32'd3);
    chk("to_buserr", 32'(bus_err), 32'd1);
    chk("to_memrd", 32'(bus.mem_rd), 32'd0);
    chk("to_valid", 32'(inst_valid), 32'd0);
    tick(); tick();
    chk("halt_sticky", 32'(fetch_state), 32'd3);

    bus.mem_ready = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_clr_buserr", 32'(bus_err), 32'd0);
    chk("rst_clr_state", 32'(fetch_state), 32'd0);
    wait_hold("rst_refetch_hold");
    chk("rst_refetch_pc", 32'(pc), 32'hC000);

    pc_inc = 1'b1; en_pc_2 = 1'b1;
    tick();
    pc_inc = 1'b0; en_pc_2 = 1'b0; bus.mem_ready = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_memrd", 32'(bus.mem_rd), 32'd0);
    tick();
    chk("midrst_state", 32'(fetch_state), 32'd0);
    chk("midrst_valid", 32'(inst_valid), 32'd0);

    // Odd vector data must be forced even.
    mem_img[16'hFFFE >> 1] = 16'hFFFF;
    bus.mem_ready = 1'b1;
    rst = 1'b0;
    wait_hold("oddvec_hold");
    chk("oddvec_pc", 32'(pc), 32'hFFFE);
    chk("oddvec_instr", 32'(instruction), 32'hFFFF);
    for (int i = 0; i < 3; i++) run_seq(seq_b[i], $sformatf("seqB_%0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
